// File: rtl/non_pipelined_fir.sv
// non_pipelined_fir
//
// Batch FIR convolution engine. While load is high the coefficient set and
// the whole input block are captured. Once load falls, one complete output
// sample is produced per clock: every sample is a full TAPS-wide MAC built
// in combinational logic. The full linear convolution is presented as one
// flattened bus, and is_completed flags that every slot has been written.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   load          level-sensitive capture / restart request (priority over compute)
//   filter_coeff  h[k] = filter_coeff[k*DATA_W +: DATA_W], signed Q1.15
//   signal_in     x[i] = signal_in[i*DATA_W +: DATA_W], signed Q1.15
//   conv_result   y[n] = conv_result[n*DATA_W +: DATA_W], signed Q1.15, saturated
//   is_completed  high once all OUT_LEN samples are valid
module non_pipelined_fir #(
  parameter int TAPS    = 20,
  parameter int SIG_LEN = 2401,
  parameter int DATA_W  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   load,
  input  logic [TAPS*DATA_W-1:0]                 filter_coeff,
  input  logic [SIG_LEN*DATA_W-1:0]              signal_in,
  output logic [(TAPS+SIG_LEN-1)*DATA_W-1:0]     conv_result,
  output logic                                   is_completed
);

  localparam int OUT_LEN = TAPS + SIG_LEN - 1;
  localparam int CNT_W   = $clog2(OUT_LEN + 1);
  localparam int ACC_W   = 2 * DATA_W + $clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] h_mem [TAPS];
  logic signed [DATA_W-1:0] x_mem [SIG_LEN];

  logic                       compute_now;
  logic [CNT_W-1:0]           diff;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    shifted;
  logic [ACC_W-DATA_W:0]      top_bits;
  logic [DATA_W-1:0]          y_sample;

  // The LOAD state also computes once load falls, so y[0] lands on the
  // same edge as the LOAD-to-COMPUTE transition.
  assign compute_now = !load && ((state == LOAD) || (state == COMPUTE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; load wins from every state.
  always_comb begin
    next_state = state;
    if (load) begin
      next_state = LOAD;
    end else begin
      case (state)
        IDLE:    next_state = IDLE;
        LOAD,
        COMPUTE: next_state = (cnt == LAST_IDX) ? DONE : COMPUTE;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Full MAC for output index cnt. Taps reaching outside x[] contribute
  // zero, which gives the zero-padded linear convolution.
  always_comb begin
    diff = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < TAPS; k++) begin
      diff = cnt - CNT_W'(k);
      if ((cnt >= CNT_W'(k)) && (diff < CNT_W'(SIG_LEN))) begin
        prod = (2*DATA_W)'(h_mem[k]) * (2*DATA_W)'(x_mem[diff]);
        acc  = acc + ACC_W'(prod);
      end
    end
  end

  // Q1.15 rescale (floor) then saturate: the value fits only if every bit
  // from the output sign bit upwards agrees.
  always_comb begin
    shifted  = acc >>> (DATA_W - 1);
    top_bits = shifted[ACC_W-1:DATA_W-1];
    y_sample = shifted[DATA_W-1:0];
    if (!((&top_bits) || !(|top_bits))) begin
      y_sample = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                  : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // Capture, clear and result-write datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      conv_result  <= '0;
      is_completed <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        h_mem[k] <= '0;
      end
      for (int i = 0; i < SIG_LEN; i++) begin
        x_mem[i] <= '0;
      end
    end else if (load) begin
      cnt          <= '0;
      conv_result  <= '0;
      is_completed <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        h_mem[k] <= filter_coeff[k*DATA_W +: DATA_W];
      end
      for (int i = 0; i < SIG_LEN; i++) begin
        x_mem[i] <= signal_in[i*DATA_W +: DATA_W];
      end
    end else if (compute_now) begin
      conv_result[cnt*DATA_W +: DATA_W] <= y_sample;
      cnt <= cnt + 1'b1;
      if (cnt == LAST_IDX) begin
        is_completed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_non_pipelined_fir.sv
// tb_non_pipelined_fir
//
// Scoreboard bench for non_pipelined_fir. Each job that is expected to run
// to completion pushes the reference convolution into a queue; a monitor
// pops and compares it when is_completed rises, and also checks latency.
module tb_non_pipelined_fir;

  localparam int TAPS    = 20;
  localparam int SIG_LEN = 2401;
  localparam int DW      = 16;
  localparam int OUT_LEN = TAPS + SIG_LEN - 1;
  localparam int CLK_P   = 10;

  logic                     clk;
  logic                     rst_n;
  logic                     load;
  logic [TAPS*DW-1:0]       filter_coeff;
  logic [SIG_LEN*DW-1:0]    signal_in;
  logic [OUT_LEN*DW-1:0]    conv_result;
  logic                     is_completed;

  int vectors;
  int miscompares;

  int h_arr [TAPS];
  int x_arr [SIG_LEN];

  logic [OUT_LEN*DW-1:0] expQ[$];
  string                 nameQ[$];

  non_pipelined_fir #(
    .TAPS(TAPS),
    .SIG_LEN(SIG_LEN),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .filter_coeff(filter_coeff),
    .signal_in(signal_in),
    .conv_result(conv_result),
    .is_completed(is_completed)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #(CLK_P/2) clk = ~clk;
  end

  // Hard stop in case something never terminates.
  initial begin
    #(CLK_P * 95000);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Scalar comparison.
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Whole-bus comparison, reporting the first differing slot.
  task automatic checkVector(input string name, input logic [OUT_LEN*DW-1:0] actual,
                             input logic [OUT_LEN*DW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      for (int n = 0; n < OUT_LEN; n++) begin
        if (actual[n*DW +: DW] !== expected[n*DW +: DW]) begin
          $display("[TB] FAIL %s: first bad slot %0d got 0x%04h, expected 0x%04h",
                   name, n, actual[n*DW +: DW], expected[n*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Behavioural reference: zero-padded linear convolution, floor rescale, clamp.
  function automatic logic [OUT_LEN*DW-1:0] refConv();
    logic [OUT_LEN*DW-1:0] r;
    longint acc;
    int j;
    r = '0;
    for (int n = 0; n < OUT_LEN; n++) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) begin
        j = n - k;
        if (j >= 0 && j < SIG_LEN) acc += longint'(h_arr[k]) * longint'(x_arr[j]);
      end
      acc = acc >>> 15;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      r[n*DW +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  function automatic longint getSlot(input int n);
    logic signed [DW-1:0] s;
    s = conv_result[n*DW +: DW];
    return longint'(s);
  endfunction

  task automatic packInputs();
    for (int k = 0; k < TAPS; k++) filter_coeff[k*DW +: DW] = DW'(h_arr[k]);
    for (int i = 0; i < SIG_LEN; i++) signal_in[i*DW +: DW] = DW'(x_arr[i]);
  endtask

  task automatic fillConst(input int hv, input int xv);
    for (int k = 0; k < TAPS; k++) h_arr[k] = hv;
    for (int i = 0; i < SIG_LEN; i++) x_arr[i] = xv;
  endtask

  // Hold load for loadCycles edges, then release; optionally register the
  // expected result with the scoreboard.
  task automatic applyStimulus(input string name, input int loadCycles, input bit push);
    packInputs();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    checkOutput({name, " completed low in load"}, longint'(is_completed), 0);
    checkOutput({name, " result cleared in load"}, longint'($countones(conv_result)), 0);
    repeat (loadCycles - 1) @(negedge clk);
    if (push) begin
      expQ.push_back(refConv());
      nameQ.push_back(name);
    end
    load = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int budget;
    budget = OUT_LEN + 10;
    while (!is_completed && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput({name, " completion"}, longint'(is_completed), 1);
  endtask

  // Monitor: latency counter and scoreboard pop on rising is_completed.
  initial begin
    int cyc;
    bit prevDone;
    logic [OUT_LEN*DW-1:0] exp_v;
    string nm;
    cyc = 0;
    prevDone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || load) cyc = 0;
      else cyc++;
      if (is_completed && !prevDone) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected completion", 1, 0);
        end else begin
          exp_v = expQ.pop_front();
          nm = nameQ.pop_front();
          checkOutput({nm, " latency"}, longint'(cyc), longint'(OUT_LEN));
          checkVector({nm, " result"}, conv_result, exp_v);
        end
      end
      prevDone = is_completed;
    end
  end

  initial begin
    logic [OUT_LEN*DW-1:0] saved;
    int amps [3];
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    load = 1'b0;
    filter_coeff = '0;
    signal_in = '0;
    amps[0] = 2000;
    amps[1] = 32767;
    amps[2] = 9000;

    // Reset state and idle with load low.
    #(CLK_P * 3 + 2);
    checkOutput("reset is_completed", longint'(is_completed), 0);
    checkOutput("reset conv_result", longint'($countones(conv_result)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle is_completed", longint'(is_completed), 0);

    // Impulse.
    fillConst(0, 0);
    h_arr[0] = 32767;
    for (int i = 0; i < SIG_LEN; i++) x_arr[i] = i;
    applyStimulus("impulse", 2, 1'b1);
    waitDone("impulse");
    checkOutput("impulse y[1]", getSlot(1), 0);
    checkOutput("impulse y[2400]", getSlot(2400), 2399);
    checkOutput("impulse y[2401]", getSlot(2401), 0);

    // Moving sum.
    fillConst(16'h0800, 16'h1000);
    applyStimulus("moving sum", 2, 1'b1);
    waitDone("moving sum");
    checkOutput("moving y[0]", getSlot(0), 16'h0100);
    checkOutput("moving y[19]", getSlot(19), 16'h1400);
    checkOutput("moving y[1000]", getSlot(1000), 16'h1400);
    checkOutput("moving y[2419]", getSlot(2419), 16'h0100);

    // Saturation both ways.
    fillConst(32767, 32767);
    applyStimulus("sat pos", 1, 1'b1);
    waitDone("sat pos");
    checkOutput("sat pos y[19]", getSlot(19), 32767);
    checkOutput("sat pos y[2400]", getSlot(2400), 32767);
    fillConst(-32768, 32767);
    applyStimulus("sat neg", 1, 1'b1);
    waitDone("sat neg");
    checkOutput("sat neg y[19]", getSlot(19), -32768);

    // Restart in the middle of COMPUTE.
    fillConst(16'h0800, 16'h1000);
    applyStimulus("aborted", 2, 1'b0);
    repeat (1000) @(negedge clk);
    fillConst(0, 16'h2000);
    h_arr[0] = 16'h4000;
    applyStimulus("restart", 3, 1'b1);
    waitDone("restart");
    checkOutput("restart y[0]", getSlot(0), 16'h1000);
    checkOutput("restart y[2400]", getSlot(2400), 16'h1000);
    checkOutput("restart y[2401]", getSlot(2401), 0);

    // Asynchronous reset mid-run, then no activity without load.
    fillConst(16'h0800, 16'h1000);
    applyStimulus("reset run", 2, 1'b0);
    repeat (500) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset conv_result", longint'($countones(conv_result)), 0);
    checkOutput("async reset is_completed", longint'(is_completed), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (OUT_LEN + 100) @(negedge clk);
    checkOutput("post reset conv_result", longint'($countones(conv_result)), 0);
    checkOutput("post reset is_completed", longint'(is_completed), 0);

    // Randomised jobs at several amplitudes.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TAPS; k++)
        h_arr[k] = int'($urandom_range(0, 2 * amps[r])) - amps[r];
      for (int i = 0; i < SIG_LEN; i++)
        x_arr[i] = int'($urandom_range(0, 2 * amps[r])) - amps[r];
      applyStimulus($sformatf("random%0d", r), 1 + r, 1'b1);
      waitDone($sformatf("random%0d", r));
    end

    // Input isolation while in DONE.
    saved = conv_result;
    for (int k = 0; k < TAPS; k++) h_arr[k] = int'($urandom_range(0, 65535)) - 32768;
    for (int i = 0; i < SIG_LEN; i++) x_arr[i] = int'($urandom_range(0, 65535)) - 32768;
    packInputs();
    repeat (20) @(negedge clk);
    checkVector("isolation result", conv_result, saved);
    checkOutput("isolation is_completed", longint'(is_completed), 1);

    checkOutput("scoreboard drained", longint'(expQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
